// File: rtl/led_sched_pkg.sv
// Shared encodings for the LED event scheduler: sequencer states, event kinds and LED colours.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    typedef enum logic {
        EV_SCORE = 1'b0,
        EV_MISS  = 1'b1
    } event_t;

    localparam logic [2:0] COLOR_MISS  = 3'b100;
    localparam logic [2:0] COLOR_SCORE = 3'b011;
    localparam logic [2:0] COLOR_OFF   = 3'b000;

    localparam logic [2:0] PLAY_STATE_DEFAULT = 3'd1;

endpackage

// File: rtl/event_fifo.sv
// One-bit event queue accepting up to two pushes per edge (push_a before push_b) and one pop.
module event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_a,
    input  logic                           data_a,
    input  logic                           push_b,
    input  logic                           data_b,
    input  logic                           pop,
    input  logic                           flush,
    output logic                           head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             acc_a;
    logic             acc_b;
    logic [CNT_W-1:0] space;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A slot freed by this edge's pop is usable by this edge's pushes.
    always_comb begin
        do_pop = pop && !empty && !flush;
        space  = CNT_W'(DEPTH) - count + CNT_W'(do_pop);
        acc_a  = push_a && !flush && (space != '0);
        acc_b  = push_b && !flush && (space > CNT_W'(acc_a));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc_a)
                mem[wr_ptr] <= data_a;
            if (acc_b)
                mem[wr_ptr + PTR_W'(acc_a)] <= data_b;
            wr_ptr <= wr_ptr + PTR_W'(acc_a) + PTR_W'(acc_b);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// Turns score/miss counter changes into queued, evenly paced flashes on the two RGB feedback LEDs.
module led_event_scheduler
    import led_sched_pkg::*;
#(
    parameter int         TICK_DIV    = 500000,
    parameter int         FLASH_TICKS = 20,
    parameter int         GAP_TICKS   = 5,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [2:0] PLAY_STATE  = PLAY_STATE_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0]                        state,
    input  logic [3:0]                        score,
    input  logic [3:0]                        miss,
    output logic [2:0]                        tri_color1,
    output logic [2:0]                        tri_color2,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending,
    output logic                              overflow
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (FLASH_TICKS > GAP_TICKS) ? FLASH_TICKS : GAP_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  FLASH_LAST = TICK_W'(FLASH_TICKS - 1);
    localparam logic [TICK_W-1:0]  GAP_LAST   = TICK_W'(GAP_TICKS - 1);

    sched_state_t       fsm;
    logic [PRESC_W-1:0] presc;
    logic [TICK_W-1:0]  ticks;
    logic [3:0]         score_q;
    logic [3:0]         miss_q;
    logic               in_play;
    logic               miss_ev;
    logic               score_ev;
    logic               pop_fire;
    logic               dropped;
    logic               tick_end;
    logic               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    assign in_play  = (state == PLAY_STATE);
    assign miss_ev  = in_play && (miss != miss_q);
    assign score_ev = in_play && (score != score_q);
    assign pop_fire = in_play && (fsm == IDLE) && !fifo_empty;
    assign tick_end = (presc == PRESC_LAST);
    assign busy     = (fsm != IDLE);

    // With one slot left only the MISS fits; with none (and no pop) every new event is lost.
    assign dropped = (fifo_full && !pop_fire)
                   ? (miss_ev || score_ev)
                   : (miss_ev && score_ev &&
                      (fifo_full || (pending == CNT_W'(FIFO_DEPTH - 1) && !pop_fire)));

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (miss_ev),
        .data_a (EV_MISS),
        .push_b (score_ev),
        .data_b (EV_SCORE),
        .pop    (pop_fire),
        .flush  (!in_play),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q  <= '0;
            miss_q   <= '0;
            overflow <= 1'b0;
        end else begin
            score_q <= score;
            miss_q  <= miss;
            if (!in_play)
                overflow <= 1'b0;
            else if (dropped)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            tri_color1 <= COLOR_OFF;
            tri_color2 <= COLOR_OFF;
        end else if (!in_play) begin
            fsm        <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            tri_color1 <= COLOR_OFF;
            tri_color2 <= COLOR_OFF;
        end else begin
            case (fsm)
                IDLE: begin
                    presc <= '0;
                    ticks <= '0;
                    if (pop_fire) begin
                        fsm <= FLASH;
                        if (fifo_head == EV_MISS) begin
                            tri_color1 <= COLOR_MISS;
                            tri_color2 <= COLOR_OFF;
                        end else begin
                            tri_color1 <= COLOR_OFF;
                            tri_color2 <= COLOR_SCORE;
                        end
                    end
                end
                FLASH: begin
                    if (tick_end && ticks == FLASH_LAST) begin
                        fsm        <= GAP;
                        presc      <= '0;
                        ticks      <= '0;
                        tri_color1 <= COLOR_OFF;
                        tri_color2 <= COLOR_OFF;
                    end else if (tick_end) begin
                        presc <= '0;
                        ticks <= ticks + TICK_W'(1);
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                GAP: begin
                    if (tick_end && ticks == GAP_LAST) begin
                        fsm   <= IDLE;
                        presc <= '0;
                        ticks <= '0;
                    end else if (tick_end) begin
                        presc <= '0;
                        ticks <= ticks + TICK_W'(1);
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                default: begin
                    fsm        <= IDLE;
                    tri_color1 <= COLOR_OFF;
                    tri_color2 <= COLOR_OFF;
                end
            endcase
        end
    end

endmodule
